// File: rtl/game_timer.sv
// Programmable down-count game timer: prescaled base tick drives a loadable
// seconds counter with one-shot / auto-reload modes and pause/resume.
module game_timer #(
    parameter int unsigned CLOCK_FREQ = 12500000,
    parameter int unsigned PRE_W      = 24,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             mode,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             done
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLOCK_FREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q,   state_d;
    logic [PRE_W-1:0] pre_q,     pre_d;
    logic [CNT_W-1:0] reload_q,  reload_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             tick_q,    tick_d;
    logic             expired_q, expired_d;
    logic             done_q,    done_d;
    logic             running_q;
    logic [CNT_W-1:0] start_cnt;

    // A start from IDLE/DONE with an exhausted count restarts from the reload value.
    assign start_cnt = (count_q == '0) ? reload_q : count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            reload_q  <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
            done_q    <= done_d;
            running_q <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        reload_d  = reload_q;
        count_d   = count_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;
        done_d    = done_q;

        if (load) begin
            reload_d = load_val;
            count_d  = load_val;
            pre_d    = '0;
            state_d  = IDLE;
            done_d   = 1'b0;
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (start && (state_q != RUN)) begin
            if (state_q == PAUSE) begin
                state_d = RUN;
            end else if (start_cnt != '0) begin
                count_d = start_cnt;
                pre_d   = '0;
                state_d = RUN;
                done_d  = 1'b0;
            end
        end else if ((state_q == RUN) && en) begin
            // Terminal prescaler edge: emit tick and step the seconds counter.
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    expired_d = 1'b1;
                    if (mode) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    assign tick    = tick_q;
    assign count   = count_q;
    assign running = running_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer with CLOCK_FREQ=4, CNT_W=4.
module tb_game_timer;

    logic       clk;
    logic       reset;
    logic       en;
    logic       start;
    logic       stop;
    logic       load;
    logic [3:0] load_val;
    logic       mode;
    logic       tick;
    logic [3:0] count;
    logic       running;
    logic       expired;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int nt;
    int ne;

    game_timer #(
        .CLOCK_FREQ(4),
        .PRE_W     (3),
        .CNT_W     (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .start   (start),
        .stop    (stop),
        .load    (load),
        .load_val(load_val),
        .mode    (mode),
        .tick    (tick),
        .count   (count),
        .running (running),
        .expired (expired),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_count(input int n, output int n_tick, output int n_exp);
        n_tick = 0;
        n_exp  = 0;
        repeat (n) begin
            cyc();
            if (tick === 1'b1) n_tick++;
            if (expired === 1'b1) n_exp++;
        end
    endtask

    task automatic do_load(input logic [3:0] v, input logic m);
        load = 1'b1; load_val = v; mode = m;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0;
        load = 1'b0; load_val = 4'd0; mode = 1'b0;

        // 1. Reset held with start asserted
        start = 1'b1;
        cyc(); cyc();
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_expired", 32'(expired), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        reset = 1'b1; start = 1'b0;
        run_count(20, nt, ne);
        check("rst_no_tick", 32'(nt), 32'd0);
        check("rst_idle", 32'(running), 32'd0);

        // 2. One-shot from 3
        do_load(4'd3, 1'b0);
        check("os_load_count", 32'(count), 32'd3);
        do_start();
        check("os_running", 32'(running), 32'd1);
        check("os_start_tick", 32'(tick), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            repeat (3) cyc();
            check("os_pre_tick", 32'(tick), 32'd0);
            cyc();
            check("os_tick", 32'(tick), 32'd1);
            check("os_count", 32'(count), 32'(3 - k));
            check("os_expired", 32'(expired), 32'(k == 3));
        end
        check("os_running_end", 32'(running), 32'd0);
        check("os_done", 32'(done), 32'd1);
        cyc();
        check("os_expired_pulse", 32'(expired), 32'd0);
        check("os_done_hold", 32'(done), 32'd1);
        run_count(12, nt, ne);
        check("os_no_more_ticks", 32'(nt), 32'd0);
        do_start();
        check("os_restart_count", 32'(count), 32'd3);
        check("os_restart_running", 32'(running), 32'd1);
        check("os_restart_done", 32'(done), 32'd0);
        repeat (4) cyc();
        check("os_restart_tick", 32'(tick), 32'd1);
        check("os_restart_cnt2", 32'(count), 32'd2);

        // 3. Auto-reload from 2
        do_load(4'd2, 1'b1);
        do_start();
        for (int k = 1; k <= 4; k++) begin
            repeat (3) cyc();
            check("ar_pre_tick", 32'(tick), 32'd0);
            cyc();
            check("ar_tick", 32'(tick), 32'd1);
            check("ar_count", 32'(count), ((k % 2) == 1) ? 32'd1 : 32'd2);
            check("ar_expired", 32'(expired), 32'((k % 2) == 0));
            check("ar_running", 32'(running), 32'd1);
        end

        // 4a. Pause via stop at prescaler 2
        do_load(4'd5, 1'b0);
        do_start();
        cyc(); cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("pz_running", 32'(running), 32'd0);
        run_count(10, nt, ne);
        check("pz_no_tick", 32'(nt), 32'd0);
        check("pz_count", 32'(count), 32'd5);
        do_start();
        check("pz_resume_running", 32'(running), 32'd1);
        check("pz_resume_tick0", 32'(tick), 32'd0);
        cyc();
        check("pz_resume_tick1", 32'(tick), 32'd0);
        cyc();
        check("pz_resume_tick2", 32'(tick), 32'd1);
        check("pz_resume_count", 32'(count), 32'd4);

        // 4b. Same hold using en=0
        do_load(4'd5, 1'b0);
        do_start();
        cyc(); cyc();
        en = 1'b0;
        run_count(10, nt, ne);
        check("en_no_tick", 32'(nt), 32'd0);
        check("en_count", 32'(count), 32'd5);
        check("en_running", 32'(running), 32'd1);
        en = 1'b1;
        cyc();
        check("en_resume_tick1", 32'(tick), 32'd0);
        cyc();
        check("en_resume_tick2", 32'(tick), 32'd1);
        check("en_resume_count", 32'(count), 32'd4);

        // 5. Priority cases
        load = 1'b1; load_val = 4'd7; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        check("pr_load_count", 32'(count), 32'd7);
        check("pr_load_running", 32'(running), 32'd0);
        do_load(4'd0, 1'b0);
        do_start();
        check("pr_zero_running", 32'(running), 32'd0);
        check("pr_zero_count", 32'(count), 32'd0);
        do_load(4'd3, 1'b0);
        do_start();
        repeat (3) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("pr_stop_term_tick", 32'(tick), 32'd0);
        check("pr_stop_term_count", 32'(count), 32'd3);
        check("pr_stop_term_running", 32'(running), 32'd0);
        do_start();
        check("pr_stop_resume_tick0", 32'(tick), 32'd0);
        cyc();
        check("pr_stop_resume_tick", 32'(tick), 32'd1);
        check("pr_stop_resume_count", 32'(count), 32'd2);

        // 6. Reset mid-run
        do_load(4'd4, 1'b0);
        do_start();
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("mr_running", 32'(running), 32'd0);
        check("mr_count", 32'(count), 32'd0);
        check("mr_expired", 32'(expired), 32'd0);
        check("mr_tick", 32'(tick), 32'd0);
        do_start();
        check("mr_start_ignored", 32'(running), 32'd0);
        run_count(8, nt, ne);
        check("mr_no_tick", 32'(nt), 32'd0);
        check("mr_no_expired", 32'(ne), 32'd0);
        do_load(4'd2, 1'b0);
        do_start();
        check("mr_reload_running", 32'(running), 32'd1);
        check("mr_reload_count", 32'(count), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Parametrised, programmable down-count timer; successor to the fixed free-running one-second tick generator.
- A prescaler divides clk into a base tick every CLOCK_FREQ cycles. A loadable seconds counter counts down on each tick.
- Supports one-shot and auto-reload modes, pause/resume and a global enable.
- Drives the brick-smasher round clock, timed power-ups and the display refresh tick.

Parameters:
CLOCK_FREQ, 12500000, clk cycles per base tick (>=2)
PRE_W, 24, prescaler width; 2^PRE_W > CLOCK_FREQ-1
CNT_W, 8, width of load value and seconds counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
en  input  1  global enable; 0 freezes prescaler and counter
start  input  1  one-cycle pulse: run / resume
stop  input  1  one-cycle pulse: pause
load  input  1  one-cycle pulse: latch load_val
load_val  input  CNT_W  reload / initial count
mode  input  1  0 = one-shot, 1 = auto-reload; sampled at every terminal tick
tick  output  1  registered one-cycle pulse per base tick while running
count  output  CNT_W  current remaining count
running  output  1  high in RUN state
expired  output  1  registered one-cycle pulse when count reaches terminal
done  output  1  level: one-shot completed

Behaviour:
- Decided interface facts: one clock (clk); reset is synchronous and active-low.
- Reset (reset==0 at an edge): state IDLE, prescaler=0, reload_reg=0, count=0. Outputs tick, running, expired and done all 0.
  - Applies mid-run with the same result; no pulse is emitted on the reset edge.
- States are IDLE, RUN, PAUSE and DONE. Command priority per edge: load > stop > start.
- load (any state):
  - Sets reload_reg<=load_val, count<=load_val and prescaler<=0.
  - Sets state<=IDLE and clears done.
  - A coincident start or stop is ignored.
- start:
  - From IDLE or DONE: if count==0, count<=reload_reg. If the resulting count is 0 (reload_reg==0), start is ignored and the state is unchanged. Otherwise prescaler<=0 and state<=RUN; done is cleared.
  - From PAUSE: state<=RUN; prescaler and count are kept, so the resume continues the partial period.
  - In RUN: no effect.
- stop:
  - In RUN: state<=PAUSE; prescaler and count are held.
  - In any other state: no effect.
- Prescaler (RUN and en==1 only):
  - If prescaler==CLOCK_FREQ-1, this is a terminal edge: prescaler<=0 and tick<=1 for one cycle. Otherwise prescaler<=prescaler+1.
  - Arithmetic is unsigned and wraps only at CLOCK_FREQ-1.
- Count update on a terminal edge (same edge as tick):
  - count>1: count<=count-1.
  - count==1, mode==0: count<=0, expired<=1, state<=DONE, done<=1.
  - count==1, mode==1: count<=reload_reg, expired<=1, state stays RUN.
- en==0: prescaler, count and state hold, and no tick/expired is produced. start, stop and load are still honoured.
- Latency:
  - The first tick is high during the cycle after the CLOCK_FREQ-th edge following the start edge (en held 1). Subsequent ticks follow every CLOCK_FREQ cycles.
  - count, tick and expired change on the same edge, so the new count is visible coincident with the tick.
- running==1 exactly when state==RUN. done stays high in DONE until load or start.
- A stop on the terminal edge wins: the state goes to PAUSE, and that edge's tick and count update are suppressed.

Test Plan:
All tests use CLOCK_FREQ=4, CNT_W=4, en=1 unless stated.
1. Reset:
   - Stimulus: hold reset=0 for 2 cycles with start=1, then release.
   - Required: tick, running, expired, done and count all 0; state IDLE; no tick for 20 cycles.
2. One-shot:
   - Stimulus: load load_val=3, mode=0; start at edge E0.
   - Required: ticks after E4, E8 and E12; count 2, 1, 0.
   - Required: expired pulses with the third tick; running falls and done=1 after E12; no further ticks.
   - Follow-up: start → count=3 and the sequence repeats.
3. Auto-reload:
   - Stimulus: load 2, mode=1; start.
   - Required: count sequence 2→1→2→1 on ticks 4 cycles apart; expired on every 2nd tick; running stays 1.
4. Pause/resume:
   - Stimulus: start with count=5; stop when the prescaler reaches 2; wait 10 cycles; start.
   - Required: count=5 and no tick during the pause; the first tick arrives 2 cycles after the resume edge.
   - Repeat with en=0 for 10 cycles instead of stop: identical hold behaviour.
5. Priority:
   - load=1 with load_val=7 and start=1 on the same edge → IDLE, count=7, running=0.
   - start with reload_reg=0 → stays IDLE.
   - stop on a terminal edge → PAUSE, count unchanged, no tick.
6. Reset mid-run:
   - Stimulus: reset=0 for 1 cycle during RUN with count=4.
   - Required: next cycle IDLE, count=0, no expired pulse; a later start is ignored until a load.
